// File: rtl/midi_preset_bank_if.sv
// Flash request/response bus between the preset bank and the SPI flash controller.
interface midi_preset_bank_if;
  logic [23:0] fl_adr;
  logic [31:0] fl_dat_o;
  logic        fl_we;
  logic        fl_tga;
  logic        fl_stb;
  logic [31:0] fl_dat_i;
  logic        fl_ack;
  logic        fl_rty;

  modport master (
    output fl_adr, fl_dat_o, fl_we, fl_tga, fl_stb,
    input  fl_dat_i, fl_ack, fl_rty
  );

  modport slave (
    input  fl_adr, fl_dat_o, fl_we, fl_tga, fl_stb,
    output fl_dat_i, fl_ack, fl_rty
  );
endinterface

// File: rtl/midi_preset_bank.sv
// Footswitch preset store: loads slots from flash, persists edits (erase + rewrite), replays on press.
// Optional PRESET_VERIFY_EN: read back every written word and rewrite it on mismatch.
module midi_preset_bank #(
  parameter int          BUTTONS         = 4,
  parameter logic [23:0] FLASH_BASE      = 24'h1ffd80,
  parameter int          WAIT_SHORT_LOG2 = 19,
  parameter int          WAIT_LONG_LOG2  = 25,
  parameter int          RETRY_MAX       = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               btn_index,
  input  logic                     save_mode,
  input  logic                     learn_valid,
  input  logic [7:0]               learn_status,
  input  logic [7:0]               learn_data1,
  input  logic [7:0]               learn_data2,
  input  logic [1:0]               learn_bytes,
  midi_preset_bank_if.master       flash,
  output logic [7:0]               tx_status,
  output logic [7:0]               tx_data1,
  output logic [7:0]               tx_data2,
  output logic [7:0]               tx_bits,
  output logic                     tx_trigger,
  output logic                     ready,
  output logic                     busy,
  output logic                     fault
);

  localparam int          CW       = (WAIT_LONG_LOG2 > WAIT_SHORT_LOG2) ? WAIT_LONG_LOG2 : WAIT_SHORT_LOG2;
  localparam logic [CW-1:0] BO_SHORT = CW'((64'd1 << WAIT_SHORT_LOG2) - 64'd1);
  localparam logic [CW-1:0] BO_LONG  = CW'((64'd1 << WAIT_LONG_LOG2) - 64'd1);
  localparam logic [3:0]  LAST     = 4'(BUTTONS);

  typedef enum logic [3:0] {
    BOOT, LOAD_REQ, LOAD_WAIT, IDLE, ERASE_REQ, ERASE_WAIT,
    WRITE_REQ, WRITE_WAIT, BACKOFF, FAULT
`ifdef PRESET_VERIFY_EN
    , VERIFY_REQ, VERIFY_WAIT
`endif
  } state_t;

  state_t        state, state_nxt, resume, retry_req;
  logic [2:0]    boot_cnt;
  logic [3:0]    ptr;
  logic [7:0]    retry_cnt;
  logic [CW-1:0] bo_cnt;
  logic [31:0]   slot_word [16];
  logic [15:0]   valid;
  logic          pending;
  logic [3:0]    btn_prev;
  logic          stb_q, we_q, tga_q;
  logic [23:0]   adr_q;
  logic [31:0]   dat_q;
  logic          is_wait;

  wire        rty        = flash.fl_rty;
  wire        ack        = flash.fl_ack && !flash.fl_rty;
  wire        last_slot  = (ptr == LAST);
  wire        retry_last = (int'(retry_cnt) + 1) >= RETRY_MAX;
  wire [23:0] slot_adr   = FLASH_BASE + {18'd0, ptr - 4'd1, 2'b00};
  wire [7:0]  learn_bits = {6'd0, learn_bytes} * 8'd10;
  wire        btn_ok     = (btn_index != 4'd0) && (btn_index <= LAST);
  wire        capture    = save_mode && learn_valid && btn_ok && (state != FAULT);
  wire        replay     = (btn_prev == 4'd0) && btn_ok && !save_mode && ready && valid[btn_index];
`ifdef PRESET_VERIFY_EN
  wire        verify_bad = (flash.fl_dat_i != dat_q);
`endif

  assign flash.fl_adr   = adr_q;
  assign flash.fl_dat_o = dat_q;
  assign flash.fl_we    = we_q;
  assign flash.fl_tga   = tga_q;
  assign flash.fl_stb   = stb_q;
  assign fault          = (state == FAULT);
  assign busy           = (state != FAULT) && (pending || capture || ((state != BOOT) && (state != IDLE)));

  always_comb begin
    state_nxt = state;
    retry_req = state;
    is_wait   = 1'b0;
    case (state)
      BOOT:       if (boot_cnt == 3'd7) state_nxt = LOAD_REQ;
      LOAD_REQ:   state_nxt = LOAD_WAIT;
      LOAD_WAIT: begin
        is_wait   = 1'b1;
        retry_req = LOAD_REQ;
        if (ack) state_nxt = last_slot ? IDLE : LOAD_REQ;
      end
      IDLE:       if (pending) state_nxt = ERASE_REQ;
      ERASE_REQ:  state_nxt = ERASE_WAIT;
      ERASE_WAIT: begin
        is_wait   = 1'b1;
        retry_req = ERASE_REQ;
        if (ack) state_nxt = BACKOFF;
      end
      WRITE_REQ:  state_nxt = WRITE_WAIT;
      WRITE_WAIT: begin
        is_wait   = 1'b1;
        retry_req = WRITE_REQ;
`ifdef PRESET_VERIFY_EN
        if (ack) state_nxt = VERIFY_REQ;
`else
        if (ack) state_nxt = BACKOFF;
`endif
      end
`ifdef PRESET_VERIFY_EN
      VERIFY_REQ: state_nxt = VERIFY_WAIT;
      VERIFY_WAIT: begin
        is_wait   = 1'b1;
        retry_req = VERIFY_REQ;
        if (ack) state_nxt = (verify_bad && retry_last) ? FAULT : BACKOFF;
      end
`endif
      BACKOFF:    if (bo_cnt == '0) state_nxt = resume;
      FAULT:      state_nxt = FAULT;
      default:    state_nxt = BOOT;
    endcase
    // A retry response overrides an ack seen in the same cycle.
    if (is_wait && rty) state_nxt = retry_last ? FAULT : BACKOFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      resume     <= BOOT;
      boot_cnt   <= 3'd0;
      ptr        <= 4'd0;
      retry_cnt  <= 8'd0;
      bo_cnt     <= '0;
      valid      <= 16'd0;
      pending    <= 1'b0;
      btn_prev   <= 4'd0;
      ready      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      tga_q      <= 1'b0;
      adr_q      <= 24'd0;
      dat_q      <= 32'd0;
      tx_status  <= 8'd0;
      tx_data1   <= 8'd0;
      tx_data2   <= 8'd0;
      tx_bits    <= 8'd0;
      tx_trigger <= 1'b0;
      for (int i = 0; i < 16; i++) slot_word[i] <= 32'd0;
    end else begin
      state      <= state_nxt;
      btn_prev   <= btn_index;
      tx_trigger <= replay;
      if (replay) {tx_status, tx_data1, tx_data2, tx_bits} <= slot_word[btn_index];
      if ((state == BACKOFF) && (bo_cnt != '0)) bo_cnt <= bo_cnt - 1'b1;
      if (is_wait && (flash.fl_ack || rty)) stb_q <= 1'b0;
      if (is_wait && rty) begin
        retry_cnt <= retry_cnt + 8'd1;
        bo_cnt    <= BO_SHORT;
        resume    <= retry_req;
      end
      case (state)
        BOOT: begin
          boot_cnt <= boot_cnt + 3'd1;
          ptr      <= 4'd1;
        end
        LOAD_REQ: begin
          stb_q <= 1'b1; we_q <= 1'b0; tga_q <= 1'b0; adr_q <= slot_adr;
        end
        LOAD_WAIT: if (ack) begin
          retry_cnt      <= 8'd0;
          slot_word[ptr] <= flash.fl_dat_i;
          valid[ptr]     <= flash.fl_dat_i[31] && (flash.fl_dat_i != 32'hFFFF_FFFF);
          if (last_slot) ready <= 1'b1;
          else           ptr   <= ptr + 4'd1;
        end
        IDLE: if (pending) pending <= 1'b0;
        ERASE_REQ: begin
          stb_q <= 1'b1; we_q <= 1'b1; tga_q <= 1'b1; adr_q <= FLASH_BASE;
        end
        ERASE_WAIT: if (ack) begin
          retry_cnt <= 8'd0;
          bo_cnt    <= BO_LONG;
          resume    <= WRITE_REQ;
          ptr       <= 4'd1;
        end
        WRITE_REQ: begin
          stb_q <= 1'b1; we_q <= 1'b1; tga_q <= 1'b0; adr_q <= slot_adr;
          dat_q <= valid[ptr] ? slot_word[ptr] : 32'hFFFF_FFFF;
        end
`ifdef PRESET_VERIFY_EN
        WRITE_WAIT: if (ack) retry_cnt <= 8'd0;
        VERIFY_REQ: begin
          stb_q <= 1'b1; we_q <= 1'b0; tga_q <= 1'b0;
        end
        VERIFY_WAIT: if (ack) begin
          bo_cnt <= BO_SHORT;
          if (verify_bad) begin
            retry_cnt <= retry_cnt + 8'd1;
            resume    <= WRITE_REQ;
          end else begin
            retry_cnt <= 8'd0;
            if (last_slot) resume <= IDLE;
            else begin
              resume <= WRITE_REQ;
              ptr    <= ptr + 4'd1;
            end
          end
        end
`else
        WRITE_WAIT: if (ack) begin
          retry_cnt <= 8'd0;
          bo_cnt    <= BO_SHORT;
          if (last_slot) resume <= IDLE;
          else begin
            resume <= WRITE_REQ;
            ptr    <= ptr + 4'd1;
          end
        end
`endif
        default: ;
      endcase
      // Capture lands last so it wins over a load or a pending clear in the same cycle.
      if (capture) begin
        slot_word[btn_index] <= {learn_status, learn_data1, learn_data2, learn_bits};
        valid[btn_index]     <= 1'b1;
        pending              <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_midi_preset_bank.sv
// Randomised bench for midi_preset_bank with a behavioural flash model and preset scoreboard.
module tb_midi_preset_bank;
  localparam logic [23:0] BASE = 24'h1ffd80;
  localparam int NB = 4, WS = 3, WL = 5, RMAX = 3;

  logic clk, rst;
  logic [3:0] btn_index;
  logic save_mode, learn_valid;
  logic [7:0] learn_status, learn_data1, learn_data2;
  logic [1:0] learn_bytes;
  logic [7:0] tx_status, tx_data1, tx_data2, tx_bits;
  logic tx_trigger, ready, busy, fault;

  midi_preset_bank_if fl_bus ();

  midi_preset_bank #(.BUTTONS(NB), .FLASH_BASE(BASE), .WAIT_SHORT_LOG2(WS),
                     .WAIT_LONG_LOG2(WL), .RETRY_MAX(RMAX)) dut (
    .clk(clk), .rst(rst), .btn_index(btn_index), .save_mode(save_mode),
    .learn_valid(learn_valid), .learn_status(learn_status), .learn_data1(learn_data1),
    .learn_data2(learn_data2), .learn_bytes(learn_bytes), .flash(fl_bus),
    .tx_status(tx_status), .tx_data1(tx_data1), .tx_data2(tx_data2), .tx_bits(tx_bits),
    .tx_trigger(tx_trigger), .ready(ready), .busy(busy), .fault(fault));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Flash model and scoreboard state
  logic [31:0] fmem [NB];
  logic [23:0] wr_log[$], rd_log[$];
  int n_erase = 0, n_rty = 0, n_rise = 0, rty_left = 0;
  logic [23:0] rty_adr = 24'd0;
  bit rand_rty_en = 0, last_rty = 0;
`ifdef PRESET_VERIFY_EN
  bit corrupt_pending = 1;
`endif

  logic [31:0] exp_word [16];
  bit exp_valid [16];

  function automatic int slot_of(input logic [23:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  initial begin
    fl_bus.fl_ack = 0; fl_bus.fl_rty = 0; fl_bus.fl_dat_i = 0;
    forever begin
      @(negedge clk);
      if (!rst || fl_bus.fl_ack || fl_bus.fl_rty) begin
        fl_bus.fl_ack = 0; fl_bus.fl_rty = 0;
      end else if (fl_bus.fl_stb && ($urandom_range(0, 1) == 0)) begin
        if (rty_left > 0 && fl_bus.fl_adr == rty_adr && !fl_bus.fl_we) begin
          fl_bus.fl_rty = 1; rty_left--; n_rty++;
        end else if (rand_rty_en && !last_rty && ($urandom_range(0, 7) == 0)) begin
          fl_bus.fl_rty = 1; last_rty = 1; n_rty++;
        end else begin
          fl_bus.fl_ack = 1; last_rty = 0;
          if (fl_bus.fl_tga) begin
            check("erase_adr", 64'(fl_bus.fl_adr), 64'(BASE));
            for (int i = 0; i < NB; i++) fmem[i] = 32'hFFFF_FFFF;
            n_erase++;
          end else if (fl_bus.fl_we) begin
            wr_log.push_back(fl_bus.fl_adr);
            fmem[slot_of(fl_bus.fl_adr)] = fl_bus.fl_dat_o;
`ifdef PRESET_VERIFY_EN
            if (corrupt_pending && slot_of(fl_bus.fl_adr) == 0) begin
              fmem[0] = fl_bus.fl_dat_o ^ 32'h1;
              corrupt_pending = 0;
            end
`endif
          end else begin
            rd_log.push_back(fl_bus.fl_adr);
            fl_bus.fl_dat_i = fmem[slot_of(fl_bus.fl_adr)];
          end
        end
      end
    end
  end

  // Bus monitor: request stability and backoff spacing between responses and the next request.
  int cyc = 0, last_kind = 0, last_cyc = 0;
  bit prev_stb = 0;
  logic [57:0] req_cap = '0;
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst) begin
        last_kind = 0; prev_stb = 0;
      end else begin
        if (fl_bus.fl_stb && !prev_stb) begin
          n_rise++;
          if (last_kind == 1) check("gap_retry", 64'(cyc - last_cyc), 64'((1 << WS) + 1));
          if (last_kind == 2) check("gap_erase", 64'(cyc - last_cyc), 64'((1 << WL) + 1));
          if (last_kind == 3) check("gap_load", 64'(cyc - last_cyc), 64'd1);
          last_kind = 0;
          req_cap = {fl_bus.fl_adr, fl_bus.fl_dat_o, fl_bus.fl_we, fl_bus.fl_tga};
        end else if (fl_bus.fl_stb) begin
          check("stb_hold", 64'({fl_bus.fl_adr, fl_bus.fl_dat_o, fl_bus.fl_we, fl_bus.fl_tga}), 64'(req_cap));
        end
        if (fl_bus.fl_rty) begin
          last_kind = 1; last_cyc = cyc;
        end else if (fl_bus.fl_ack) begin
          if (req_cap[0])                     last_kind = 2;
          else if (!req_cap[1] && !ready)     last_kind = 3;
          else                                last_kind = 0;
          last_cyc = cyc;
        end
        prev_stb = fl_bus.fl_stb;
      end
    end
  end

  bit exp_ready = 0, exp_fault = 0;

  task automatic capture(input logic [3:0] b, input logic [7:0] s, d1, d2, input logic [1:0] n);
    @(negedge clk);
    save_mode = 1; btn_index = b; learn_valid = 1;
    learn_status = s; learn_data1 = d1; learn_data2 = d2; learn_bytes = n;
    #1;
    if (exp_fault) check("busy_in_fault", 64'(busy), 64'd0);
    else if (b >= 1 && b <= NB) check("busy_capture", 64'(busy), 64'd1);
    if (b >= 1 && b <= NB && !exp_fault) begin
      exp_word[b] = {s, d1, d2, 8'(n) * 8'd10};
      exp_valid[b] = 1;
    end
    @(negedge clk);
    learn_valid = 0; save_mode = 0; btn_index = 0;
  endtask

  task automatic press(input logic [3:0] b);
    bit exp_t;
    exp_t = exp_ready && (b >= 1) && (b <= NB) && exp_valid[b];
    @(negedge clk); save_mode = 0; btn_index = b;
    @(posedge clk); #1;
    check($sformatf("trig_btn%0d", b), 64'(tx_trigger), 64'(exp_t));
    if (exp_t) check("tx_word", 64'({tx_status, tx_data1, tx_data2, tx_bits}), 64'(exp_word[b]));
    @(posedge clk); #1;
    check("no_repeat", 64'(tx_trigger), 64'd0);
    @(negedge clk); btn_index = 0;
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (!ready && k < budget) begin @(posedge clk); #1; k++; end
    check("ready_reached", 64'(ready), 64'd1);
    exp_ready = ready;
  endtask

  task automatic wait_quiet(input int budget);
    int k = 0;
    @(posedge clk); #1;
    while (busy && k < budget) begin @(posedge clk); #1; k++; end
    check("busy_cleared", 64'(busy), 64'd0);
  endtask

  task automatic check_flash();
    for (int i = 1; i <= NB; i++)
      check($sformatf("flash_slot%0d", i), 64'(fmem[i-1]), 64'(exp_valid[i] ? exp_word[i] : 32'hFFFF_FFFF));
  endtask

  task automatic model_from_flash();
    for (int i = 0; i < 16; i++) begin exp_valid[i] = 0; exp_word[i] = 0; end
    for (int i = 1; i <= NB; i++) begin
      exp_word[i]  = fmem[i-1];
      exp_valid[i] = fmem[i-1][31] && (fmem[i-1] != 32'hFFFF_FFFF);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 0; exp_ready = 0;
    repeat (3) @(negedge clk);
    rd_log.delete(); wr_log.delete();
    rst = 1;
  endtask

  initial begin
    logic [23:0] exp_wr[$];
    int e0, r0;
    rst = 1; btn_index = 0; save_mode = 0; learn_valid = 0;
    learn_status = 0; learn_data1 = 0; learn_data2 = 0; learn_bytes = 0;
    fmem[0] = 32'hB02E_7F1E;
    for (int i = 1; i < NB; i++) fmem[i] = 32'hFFFF_FFFF;
    model_from_flash();
    #1 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", 64'(fl_bus.fl_stb), 64'd0);
    check("rst_flash_out", 64'({fl_bus.fl_adr, fl_bus.fl_we, fl_bus.fl_tga}), 64'd0);
    check("rst_dat_o", 64'(fl_bus.fl_dat_o), 64'd0);
    check("rst_tx", 64'({tx_status, tx_data1, tx_data2, tx_bits, tx_trigger}), 64'd0);
    check("rst_flags", 64'({ready, busy, fault}), 64'd0);
    @(negedge clk); rst = 1;

    // Boot load
    wait_ready(400);
    check("load_count", 64'(rd_log.size()), 64'(NB));
    for (int i = 0; i < rd_log.size() && i < NB; i++)
      check("load_adr", 64'(rd_log[i]), 64'(BASE + 24'(i * 4)));
    check("busy_after_load", 64'(busy), 64'd0);
    press(1); press(2); press(5); press(0);

    // Single capture: one erase, full rewrite
    e0 = n_erase; wr_log.delete();
    capture(3, 8'hC0, 8'h42, 8'h00, 2'd2);
    check("slot3_word", 64'(exp_word[3]), 64'(32'hC042_0014));
    wait_quiet(2000);
    check("erase_count", 64'(n_erase - e0), 64'd1);
    exp_wr.delete();
`ifdef PRESET_VERIFY_EN
    exp_wr.push_back(BASE);
`endif
    for (int i = 0; i < NB; i++) exp_wr.push_back(BASE + 24'(i * 4));
    check("write_count", 64'(wr_log.size()), 64'(exp_wr.size()));
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      check("write_adr", 64'(wr_log[i]), 64'(exp_wr[i]));
    check_flash();
    check("fault_after_save", 64'(fault), 64'd0);

    // Out-of-range capture is ignored
    e0 = n_erase;
    capture(6, 8'h90, 8'h01, 8'h02, 2'd3);
    #1 check("busy_ignored", 64'(busy), 64'd0);
    repeat (60) @(posedge clk);
    check("no_erase_ignored", 64'(n_erase - e0), 64'd0);

    // Second capture while slot 2 write is in flight
    e0 = n_erase; wr_log.delete();
    capture(2, 8'h90, 8'h3C, 8'h64, 2'd3);
    r0 = 0;
    while (!(fl_bus.fl_stb && fl_bus.fl_we && !fl_bus.fl_tga && fl_bus.fl_adr == BASE + 24'd4) && r0 < 2000) begin
      @(posedge clk); #1; r0++;
    end
    check("saw_slot2_write", 64'(r0 < 2000), 64'd1);
    capture(4, 8'h80, 8'h11, 8'h22, 2'd3);
    wait_quiet(4000);
    check("erase_count2", 64'(n_erase - e0), 64'd2);
    check("write_count2", 64'(wr_log.size()), 64'(2 * NB));
    check_flash();

    // Random captures and presses, with sporadic single retries
    rand_rty_en = 1;
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 40)) @(posedge clk);
      if ($urandom_range(0, 2) == 0) press(4'($urandom_range(1, 6)));
      else capture(4'($urandom_range(1, 5)), 8'($urandom), 8'($urandom), 8'($urandom),
                   2'($urandom_range(1, 3)));
    end
    wait_quiet(5000);
    rand_rty_en = 0;
    check_flash();
    for (int b = 1; b <= NB; b++) press(4'(b));
    check("fault_after_random", 64'(fault), 64'd0);

    // Reset in the middle of an erase
    capture(1, 8'hB5, 8'h07, 8'h7F, 2'd3);
    r0 = 0;
    while (!(fl_bus.fl_stb && fl_bus.fl_tga && !fl_bus.fl_ack && !fl_bus.fl_rty) && r0 < 2000) begin
      @(posedge clk); #1; r0++;
    end
    check("saw_erase", 64'(r0 < 2000), 64'd1);
    #1 rst = 0;
    #1 check("async_stb_drop", 64'(fl_bus.fl_stb), 64'd0);
    check("rst_flags2", 64'({ready, busy, fault}), 64'd0);
    exp_ready = 0;
    repeat (3) @(negedge clk);
    rd_log.delete(); wr_log.delete();
    rst = 1;
    model_from_flash();
    wait_ready(400);
    check("reload_first_adr", 64'(rd_log.size() > 0 ? rd_log[0] : 24'd0), 64'(BASE));
    check("reload_count", 64'(rd_log.size()), 64'(NB));
    for (int b = 1; b <= NB; b++) press(4'(b));

    // Two retries on the slot-2 read are absorbed
    n_rty = 0; rty_adr = BASE + 24'd4; rty_left = 2;
    do_reset();
    model_from_flash();
    wait_ready(600);
    check("retry_seen", 64'(n_rty), 64'd2);
    check("retry_no_fault", 64'(fault), 64'd0);
    check("retry_reads", 64'(rd_log.size()), 64'(NB));

    // RETRY_MAX consecutive retries end in a sticky fault
    n_rty = 0; rty_left = RMAX;
    do_reset();
    r0 = 0;
    while (!fault && r0 < 1000) begin @(posedge clk); #1; r0++; end
    check("fault_set", 64'(fault), 64'd1);
    exp_fault = 1;
    check("fault_ready", 64'(ready), 64'd0);
    check("fault_busy", 64'(busy), 64'd0);
    r0 = n_rise;
    capture(1, 8'hC1, 8'h05, 8'h00, 2'd2);
    repeat (60) @(posedge clk);
    #1;
    check("fault_no_requests", 64'(n_rise - r0), 64'd0);
    check("fault_stb", 64'(fl_bus.fl_stb), 64'd0);
    check("fault_sticky", 64'(fault), 64'd1);
    press(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running, expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end
endmodule

// File: doc/midi_preset_bank.md
# midi_preset_bank

Parametrised preset store for the MIDI controller. It holds one learned MIDI message per footswitch for up to `BUTTONS` switches. It loads all slots from SPI flash after reset and persists edits with a sector erase followed by a full rewrite, retrying and backing off on flash stalls. When a switch is pressed outside save mode it replays the stored message to `midi_out`. It sits between `buttons`/`midi_in` (inputs), `spi_flash` (strobe/ack/retry bus) and `midi_out`.

## Interface
- `BUTTONS`, 4: number of preset slots, legal range 1..15.
- `FLASH_BASE`, 24'h1ffd80: flash byte address of slot 1. Slot n is at `FLASH_BASE + (n-1)*4`.
- `WAIT_SHORT_LOG2`, 19: backoff of 2^N clk cycles after a retry or a word write.
- `WAIT_LONG_LOG2`, 25: backoff of 2^N clk cycles after a sector erase.
- `RETRY_MAX`, 3: consecutive `fl_rty` responses tolerated per operation before FAULT.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `btn_index` in 4: pressed switch, 1..BUTTONS; 0 means none.
- `save_mode` in 1: learn mode from `buttons`.
- `learn_valid` in 1: a completed MIDI input message is available.
- `learn_status`, `learn_data1`, `learn_data2` in 8 each: the learned message.
- `learn_bytes` in 2: byte count of the learned message, 1..3.
- `fl_adr` out 24, `fl_dat_o` out 32, `fl_we` out 1, `fl_tga` out 1 (1 = erase sector), `fl_stb` out 1: flash request.
- `fl_dat_i` in 32, `fl_ack` in 1, `fl_rty` in 1: flash response.
- `tx_status`, `tx_data1`, `tx_data2` out 8 each, `tx_bits` out 8, `tx_trigger` out 1: replay port to `midi_out`.
- `ready` out 1: load complete, replay enabled.
- `busy` out 1: a flash operation is pending.
- `fault` out 1: retry budget exhausted.

## Operation
- Slot word format: {status, data1, data2, bits}, where bits = bytes*10.
- A slot is valid iff status[7]=1 and word ≠ 32'hFFFFFFFF; blank flash therefore reads as invalid.
- FSM states: BOOT, LOAD_REQ, LOAD_WAIT, IDLE, ERASE_REQ, ERASE_WAIT, WRITE_REQ, WRITE_WAIT, BACKOFF, FAULT.
- BOOT: waits 8 cycles, then enters LOAD_REQ with slot pointer = 1.
- LOAD: read each slot in turn into the register array and set or clear its valid bit. After slot BUTTONS, go to IDLE and set `ready`.
- Capture: on `btn_index`≠0 && `save_mode` && `learn_valid`, with `btn_index` ≤ BUTTONS:
  - the slot is written in the same cycle and marked valid;
  - the `pending` flag is set.
  - Capture is accepted in every state except FAULT.
- IDLE with `pending` → ERASE_REQ at `FLASH_BASE`, clear `pending`. Erase ack → BACKOFF (long) → WRITE_REQ for slots 1..BUTTONS. Each write ack → BACKOFF (short).
- Invalid slots are written as 32'hFFFFFFFF.
- A capture during erase/write sets `pending` again. The current sequence finishes, then IDLE restarts it from ERASE.
- `fl_rty`: drop `fl_stb`, increment the retry counter, BACKOFF (short), then reissue the same request. The counter clears on every ack. When the counter reaches RETRY_MAX, go to FAULT.
- FAULT is sticky until `rst`. It sets `fault`, clears `busy`, and leaves replay enabled only if `ready` was already set.
- Replay: on a 0→nonzero edge of `btn_index`, with `save_mode`=0, `ready`, and the slot valid:
  - latch the slot onto the `tx_*` outputs;
  - pulse `tx_trigger` for 1 cycle.
  - A held switch produces no repeat. `btn_index` > BUTTONS is ignored.

## Timing
- Reset values: `fl_stb`=0, `fl_we`=0, `fl_tga`=0, `fl_adr`=0, `fl_dat_o`=0, all `tx_*`=0, `ready`=0, `busy`=0, `fault`=0, all valid bits=0, `pending`=0.
- Reset mid-transaction drops `fl_stb` asynchronously. No state survives reset.
- `fl_stb` rises 1 cycle after entering a *_REQ state. It holds with stable `fl_adr`/`fl_dat_o`/`fl_we`/`fl_tga` until `fl_ack` or `fl_rty` is sampled high, then falls in the next cycle.
- If `fl_ack` and `fl_rty` are high together, `fl_rty` wins.
- Load data is registered on the `fl_ack` cycle, and the valid bit updates in the same cycle.
- Replay latency: `tx_trigger` is high 1 cycle after the qualifying `btn_index` edge is sampled.
- `busy` is high from the capture cycle until the return to IDLE with `pending`=0, and high throughout the load.

## Configuration
- `PRESET_VERIFY_EN`:
  - Defined: each write ack is followed by a read-back of the same address. A mismatch counts as one retry and reissues the write. A match proceeds to BACKOFF.
  - Undefined: no read-back; the write ack alone advances the sequence.

## Test plan
- Boot with the flash model returning {B0,2E,7F,1E} for slot 1 and FFFFFFFF elsewhere → after load, `ready`=1. A press on btn 1 gives `tx_trigger` pulse with B0/2E/7F/1E. A press on btn 2 gives no trigger.
- `save_mode`=1, btn 3, learn C0/42/00, bytes=2 → one erase at 1ffd80, then 4 writes at 1ffd80..1ffd8c, with slot 3 = C042_0014 and the others FFFFFFFF. `busy` is low afterwards.
- Flash answers `fl_rty` twice, then ack, on the slot-2 read → two short backoffs, same address reissued, load completes, `fault`=0. With RETRY_MAX rty responses → `fault`=1, FSM stuck, `ready`=0.
- Second capture while WRITE of slot 2 is in flight → the sequence completes, then a second erase plus full rewrite containing both edits.
- Assert `rst` while `fl_stb`=1 during the erase → `fl_stb` drops without waiting for a clock edge. Reload restarts at slot 1.
- With `PRESET_VERIFY_EN`, the model corrupts the first slot-1 write → read-back mismatch, the write is reissued once, and the sequence completes with `fault`=0.
